// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the dual-clock FIFO.
// Issues FIFO reads from registered occupancy only, captures the returning
// word into a 3-entry circular buffer and presents it as a valid/ready stream.
// Also provides a synchronous flush and a wrapping count of delivered words.
module fifo_rd_stream #(
  parameter int DW = 104,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush,
  output logic [1:0]    buf_count,
  output logic [CW-1:0] pop_total
);

  logic [DW-1:0] mem [3];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [1:0]    occ;
  logic          inflight;
  logic          capture;
  logic          pop;
  logic [2:0]    level;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue and stream outputs; the read strobe ignores out_ready so no
  // combinational path exists from downstream back to the FIFO. It is also
  // held low while nreset is asserted so no read is issued during reset.
  always_comb begin
    level      = {1'b0, occ} + {2'b00, inflight};
    fifo_rd_en = nreset & ~fifo_empty & ~flush & (level < 3'd3);
    out_valid  = (occ != 2'd0);
    out_data   = out_valid ? mem[rd_ptr] : '0;
    pop        = out_valid & out_ready;
    capture    = inflight & ~flush;
    buf_count  = occ;
  end

  // Pointer, occupancy and in-flight tracking; flush discards everything,
  // including the word returning in the flush cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({capture, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage: the returning FIFO word lands at wr_ptr.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < 3; i++) mem[i] <= '0;
    end else if (capture) begin
      mem[wr_ptr] <= fifo_dout;
    end
  end

  // Delivered-word counter; pops in a flush cycle still count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pop_total <= '0;
    end else if (pop) begin
      pop_total <= pop_total + CW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a FIFO model feeds the DUT, words
// read from the FIFO are queued as expected output and compared on delivery.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          nreset;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          out_ready;
  logic          flush;
  logic          fifo_rd_en, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    buf_count;
  logic [31:0]   pop_total;
  logic          w_rd_en, w_valid;
  logic [DW-1:0] w_data;
  logic [1:0]    w_buf;
  logic [3:0]    w_pop_total;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DW(DW), .CW(32)) u_dut (
    .clk(clk), .nreset(nreset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .buf_count(buf_count), .pop_total(pop_total)
  );

  fifo_rd_stream #(.DW(DW), .CW(4)) u_wrap (
    .clk(clk), .nreset(nreset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(w_rd_en), .out_valid(w_valid), .out_data(w_data),
    .out_ready(out_ready), .flush(flush), .buf_count(w_buf), .pop_total(w_pop_total)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  arr_word;
  logic [7:0]  last_word;
  logic        inflight_m;
  int unsigned cnt;
  bit          ready_m, stall_m, flush_m;
  int          cyc, reads, first_rd_cyc, first_pop_cyc, last_pop_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive at the negedge, sample 1 ns later, advance model.
  task automatic tick();
    logic       exp_rd;
    logic [2:0] lvl;
    fifo_empty = (fifo_q.size() == 0) || stall_m;
    out_ready  = ready_m;
    flush      = flush_m;
    fifo_dout  = inflight_m ? arr_word : 8'($urandom);
    #1;
    lvl    = 3'(exp_q.size()) + {2'b00, inflight_m};
    exp_rd = !fifo_empty && !flush_m && (lvl < 3'd3);
    check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check("buf_count", 32'(buf_count), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", 32'(out_data), 32'(exp_q[0]));
    else                   check("out_data_idle", 32'(out_data), 32'h0);
    check("pop_total", pop_total, cnt);
    check("wrap_total", 32'(w_pop_total), 32'(cnt[3:0]));
    check("wrap_rd_en", 32'(w_rd_en), 32'(exp_rd));
    check("wrap_data", 32'(w_data), 32'(out_data));
    if (exp_rd && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (exp_q.size() != 0 && ready_m) begin
      last_word = exp_q.pop_front();
      cnt++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (inflight_m && !flush_m) exp_q.push_back(arr_word);
    if (flush_m) exp_q.delete();
    if (exp_rd) begin
      arr_word = fifo_q.pop_front();
      reads++;
    end
    inflight_m = exp_rd;
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset with the FIFO reporting data, check idle outputs, release.
  task automatic apply_reset();
    nreset = 1'b0; fifo_empty = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_buf", 32'(buf_count), 32'h0);
    check("rst_pop", pop_total, 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_wrap_pop", 32'(w_pop_total), 32'h0);
    fifo_q.delete(); exp_q.delete();
    inflight_m = 1'b0; cnt = 0; reads = 0; cyc = 0;
    first_rd_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    ready_m = 1'b0; stall_m = 1'b0; flush_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    int budget;
    int nw;
    nreset = 1'b0; fifo_empty = 1'b0; out_ready = 1'b0; flush = 1'b0; fifo_dout = '0;
    @(negedge clk);

    // Streaming
    apply_reset();
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    ready_m = 1'b1;
    budget = 0;
    while (cnt < 16 && budget < 60) begin tick(); budget++; end
    for (int i = 0; i < 3; i++) tick();
    check("stream_first_rd", 32'(first_rd_cyc), 32'h0);
    check("stream_latency", 32'(first_pop_cyc - first_rd_cyc), 32'd2);
    check("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd15);
    check("stream_count", pop_total, 32'd16);
    check("stream_last", 32'(last_word), 32'h10);

    // Backpressure
    apply_reset();
    for (int i = 1; i <= 5; i++) fifo_q.push_back(8'(i));
    ready_m = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("bp_reads", 32'(reads), 32'd3);
    check("bp_buf", 32'(buf_count), 32'd3);
    check("bp_rd_en", 32'(fifo_rd_en), 32'h0);
    check("bp_data", 32'(out_data), 32'h01);
    ready_m = 1'b1;
    budget = 0;
    while (cnt < 5 && budget < 20) begin tick(); budget++; end
    check("bp_count", 32'(cnt), 32'd5);
    check("bp_last", 32'(last_word), 32'h05);

    // Flush with two buffered words and one in flight
    apply_reset();
    for (int i = 1; i <= 10; i++) fifo_q.push_back(8'(i));
    ready_m = 1'b0;
    budget = 0;
    while (!(exp_q.size() == 2 && inflight_m) && budget < 10) begin tick(); budget++; end
    check("fl_setup", 32'(exp_q.size() == 2 && inflight_m), 32'h1);
    flush_m = 1'b1;
    tick();
    flush_m = 1'b0;
    check("fl_buf", 32'(buf_count), 32'h0);
    check("fl_valid", 32'(out_valid), 32'h0);
    ready_m = 1'b1;
    budget = 0;
    while (cnt < 1 && budget < 10) begin tick(); budget++; end
    check("fl_next_word", 32'(last_word), 32'h04);
    budget = 0;
    while (cnt < 7 && budget < 20) begin tick(); budget++; end
    check("fl_last_word", 32'(last_word), 32'h0a);
    check("fl_pop_total", pop_total, 32'd7);

    // Random stall, backpressure and occasional flush
    apply_reset();
    nw = 0;
    budget = 0;
    while (!(nw == 1000 && fifo_q.size() == 0 && exp_q.size() == 0 && !inflight_m)
           && budget < 20000) begin
      if (fifo_q.size() < 4 && nw < 1000) begin fifo_q.push_back(8'(nw)); nw++; end
      ready_m = ($urandom_range(0, 9) < 7);
      stall_m = ($urandom_range(0, 9) < 3);
      flush_m = ($urandom_range(0, 49) == 0);
      tick();
      budget++;
    end
    ready_m = 1'b0; stall_m = 1'b0; flush_m = 1'b0;
    check("rand_done", 32'(budget < 20000), 32'h1);

    // Reset in the middle of traffic
    apply_reset();
    for (int i = 1; i <= 3; i++) fifo_q.push_back(8'(i));
    for (int i = 0; i < 3; i++) tick();
    apply_reset();

    // Counter wrap on the 4-bit instance
    for (int i = 1; i <= 17; i++) fifo_q.push_back(8'(i + 32));
    ready_m = 1'b1;
    budget = 0;
    while (cnt < 17 && budget < 60) begin tick(); budget++; end
    tick();
    check("wrap_final", 32'(w_pop_total), 32'd1);
    check("wrap_main", pop_total, 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer for the dual-clock FIFO. Lives in the read clock domain.
- Drives the FIFO's rd_en/empty/dout (data valid the cycle after rd_en) and presents a standard valid/ready stream to downstream logic.
- Contains a 3-entry output buffer plus in-flight read tracking, so it sustains one word per cycle with no combinational path from out_ready to fifo_rd_en.
- Also provides a synchronous flush and a running pop counter.

Parameters:
DW, 104, data width; matches the FIFO width.
CW, 32, width of the delivered-word counter.

Ports:
clk  input  1  read-domain clock; the same clock as the FIFO rd_clk.
nreset  input  1  async reset, active-low.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DW  FIFO read data; valid the cycle after fifo_rd_en.
fifo_rd_en  output  1  FIFO read strobe.
out_valid  output  1  out_data holds a valid word.
out_data  output  DW  head word of the buffer.
out_ready  input  1  downstream accepts the word when out_valid is also high.
flush  input  1  sync discard of all buffered and in-flight words.
buf_count  output  2  words held in the buffer (0..3).
pop_total  output  CW  words delivered downstream; wraps modulo 2^CW.

Behaviour:
- Reset: the interface is "one clock; reset is asynchronous and active-low". Asserting nreset clears all state immediately:
  - buffer and inflight flag cleared
  - buf_count=0, pop_total=0
  - out_valid=0, out_data=0, fifo_rd_en=0
- Buffer:
  - 3-entry circular buffer: wr_ptr and rd_ptr count 0..2 and wrap 2->0.
  - Occupancy register is 0..3. buf_count equals occupancy.
- inflight register:
  - Set in the cycle after fifo_rd_en=1, meaning fifo_dout is valid this cycle.
  - In that cycle, fifo_dout is written at wr_ptr.
- Issue rule:
  - fifo_rd_en = !fifo_empty & !flush & (buf_count + inflight < 3).
  - This is a function of registered state, fifo_empty and flush only; it never depends on out_ready.
- Pop:
  - pop = out_valid & out_ready.
  - out_valid = (buf_count != 0).
  - out_data = entry at rd_ptr, or 0 when empty.
  - Holding rule: while out_valid=1 and out_ready=0, out_data stays stable.
- Simultaneous capture and pop in one cycle:
  - occupancy unchanged; both pointers advance.
  - Valid with occupancy 0: the captured word becomes visible the next cycle. There is no fall-through, so latency from fifo_rd_en to out_valid is 2 cycles.
- Invariant: buf_count + inflight <= 3 at all times. Capture is never refused; overflow is impossible by construction.
- Throughput: with fifo_empty=0 and out_ready=1 held, steady state delivers 1 word/cycle.
- Flush (sampled at a clk edge):
  - Occupancy, pointers and inflight clear at the next edge. The word arriving in the flush cycle is discarded.
  - fifo_rd_en=0 during flush.
  - pop_total is not cleared.
  - Any pop in the flush cycle still counts.
- pop_total increments by 1 on every pop and wraps from 2^CW-1 to 0.
- Reset mid-operation: in-flight and buffered data are lost. The FIFO shares nreset and is reset alongside.
- fifo_empty is trusted. The block never asserts fifo_rd_en while fifo_empty=1.

Test Plan:
- Reset/idle: nreset=0 with fifo_empty=0 -> fifo_rd_en=0, out_valid=0, buf_count=0, pop_total=0. Release -> fifo_rd_en=1 on the first edge.
- Streaming: DW=8, FIFO preloaded with 0x01..0x10, out_ready=1 -> out_data 0x01..0x10 on 16 consecutive cycles starting 2 cycles after the first rd_en; pop_total=16; no duplicates or gaps.
- Backpressure: out_ready=0 with FIFO holding 5 words -> exactly 3 reads issued, buf_count=3, fifo_rd_en=0, out_data=0x01 held stable. Set out_ready=1 -> 0x01..0x05 delivered in order.
- Random stall: 1000 words with random fifo_empty and out_ready -> scoreboard exact order match; buf_count + inflight never exceeds 3; no rd_en while empty.
- Flush: with buf_count=2 and a read in flight, pulse flush -> next cycle buf_count=0 and out_valid=0, the in-flight word is never output, and the next delivered word is the following FIFO entry.
- Counter wrap: CW=4, deliver 17 words -> pop_total=1.
